mix_col_stream: RTL

- Parametrised streaming MixColumns / InvMixColumns unit for the low-area AES datapath.
- Accepts one AES state column as 4 bytes, delivered over 4/LANES beats. Emits the transformed 32-bit column with a valid/ready handshake.
- Tracks the column index within the 128-bit state and supports a final-round bypass.
- Sits between ShiftRows and AddRoundKey in the round pipeline.

---
 rtl/mix_col_stream.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/mix_col_stream.sv
// Streaming AES MixColumns / InvMixColumns: gathers one state column over 4/LANES
// beats and presents the transformed 32-bit word behind a registered valid/ready output.
module mix_col_stream #(
  parameter int LANES    = 1,
  parameter bit ENC_ONLY = 1'b0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [8*LANES-1:0] d_in,
  input  logic               mode,
  input  logic               bypass,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [31:0]        col_out,
  output logic [1:0]         col_idx,
  output logic               state_last
);

  // Handshake: a beat transfers on a rising edge where in_valid && in_ready; a column
  // transfers where out_valid && out_ready. A producer never withdraws valid or changes
  // its payload until the transfer, and ready never depends on valid.

  localparam int BEATS = 4 / LANES;
  localparam logic [1:0] LAST_BEAT = 2'(BEATS - 1);

  typedef logic [3:0][7:0] col_t;

  logic [1:0] beat_cnt_q, beat_cnt_d;
  col_t       acc_q, acc_d;
  logic       mode_q, mode_d;
  logic       bypass_q, bypass_d;
  logic       out_valid_q, out_valid_d;
  logic [31:0] col_out_q, col_out_d;
  logic [1:0] col_idx_q, col_idx_d;
  logic [1:0] next_idx_q, next_idx_d;

  logic first_beat, last_beat, stall, accept, col_done;
  logic mode_eff, bypass_eff;
  col_t merged, enc_col, dec_col, f_col;

  function automatic logic [7:0] xt(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] mul_9(input logic [7:0] a);
    return xt(xt(xt(a))) ^ a;
  endfunction

  function automatic logic [7:0] mul_b(input logic [7:0] a);
    return xt(xt(xt(a))) ^ xt(a) ^ a;
  endfunction

  function automatic logic [7:0] mul_d(input logic [7:0] a);
    return xt(xt(xt(a))) ^ xt(xt(a)) ^ a;
  endfunction

  function automatic logic [7:0] mul_e(input logic [7:0] a);
    return xt(xt(xt(a))) ^ xt(xt(a)) ^ xt(a);
  endfunction

  assign first_beat = (beat_cnt_q == 2'd0);
  assign last_beat  = (beat_cnt_q == LAST_BEAT);
  assign stall      = out_valid_q && !out_ready;
  // Only the column-completing beat needs the output register, so earlier beats flow on.
  assign in_ready   = rst && !clr && !(last_beat && stall);
  assign accept     = in_valid && in_ready;
  assign col_done   = accept && last_beat;

  // Mode and bypass come straight from the inputs on the first beat of a column.
  assign mode_eff   = ENC_ONLY ? 1'b1 : (first_beat ? mode : mode_q);
  assign bypass_eff = first_beat ? bypass : bypass_q;

  for (genvar r = 0; r < 4; r++) begin : g_merge
    localparam int BEAT = r / LANES;
    localparam int LANE = r % LANES;
    assign merged[r] = (beat_cnt_q == 2'(BEAT)) ? d_in[8*LANE +: 8] : acc_q[r];
  end

  for (genvar r = 0; r < 4; r++) begin : g_enc
    assign enc_col[r] = xt(merged[r]) ^ xt(merged[(r+1)%4]) ^ merged[(r+1)%4]
                      ^ merged[(r+2)%4] ^ merged[(r+3)%4];
  end

  if (ENC_ONLY) begin : g_enc_only
    assign dec_col = '0;
  end else begin : g_dec
    for (genvar r = 0; r < 4; r++) begin : g_row
      assign dec_col[r] = mul_e(merged[r]) ^ mul_b(merged[(r+1)%4])
                        ^ mul_d(merged[(r+2)%4]) ^ mul_9(merged[(r+3)%4]);
    end
  end

  assign f_col = bypass_eff ? merged : (mode_eff ? enc_col : dec_col);

  always_comb begin
    beat_cnt_d  = beat_cnt_q;
    acc_d       = acc_q;
    mode_d      = mode_q;
    bypass_d    = bypass_q;
    out_valid_d = out_valid_q;
    col_out_d   = col_out_q;
    col_idx_d   = col_idx_q;
    next_idx_d  = next_idx_q;

    if (accept) begin
      acc_d      = merged;
      beat_cnt_d = last_beat ? 2'd0 : beat_cnt_q + 2'd1;
      if (first_beat) begin
        mode_d   = mode;
        bypass_d = bypass;
      end
    end

    if (col_done) begin
      out_valid_d = 1'b1;
      col_out_d   = f_col;
      col_idx_d   = next_idx_q;
      next_idx_d  = next_idx_q + 2'd1;
    end else if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    if (clr) begin
      beat_cnt_d  = 2'd0;
      out_valid_d = 1'b0;
      next_idx_d  = 2'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      beat_cnt_q  <= 2'd0;
      acc_q       <= '0;
      mode_q      <= 1'b1;
      bypass_q    <= 1'b0;
      out_valid_q <= 1'b0;
      col_out_q   <= 32'd0;
      col_idx_q   <= 2'd0;
      next_idx_q  <= 2'd0;
    end else begin
      beat_cnt_q  <= beat_cnt_d;
      acc_q       <= acc_d;
      mode_q      <= mode_d;
      bypass_q    <= bypass_d;
      out_valid_q <= out_valid_d;
      col_out_q   <= col_out_d;
      col_idx_q   <= col_idx_d;
      next_idx_q  <= next_idx_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign col_out    = col_out_q;
  assign col_idx    = col_idx_q;
  assign state_last = out_valid_q && (col_idx_q == 2'd3);

endmodule
